// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: operand forwarding, load-use and redirect handling,
// multi-cycle op sequencing and a saturating stall-cycle counter.
module ex_hazard_ctrl #(
  parameter int          MC_LAT     = 4,
  parameter logic [1:0]  LOAD_WBSEL = 2'b00,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic [1:0]       wbselE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             pcselE,
  input  logic             mc_reqE,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushE,
  output logic             mc_go,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int CW = $clog2(MC_LAT) + 1;
  localparam logic [CW-1:0]    CNT_START = CW'((MC_LAT > 1) ? (MC_LAT - 2) : 0);
  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  logic [1:0] fwd_a, fwd_b;
  logic       lu;
  logic       mc_hold;
  logic       mc_start;
  logic       stall_fd;
  logic       stall_e;
  logic       flush_e;

  always_comb begin
    fwd_a = 2'b00;
    if (regwriteM && (rdM != 5'd0) && (rdM == rs1E))      fwd_a = 2'b10;
    else if (regwriteW && (rdW != 5'd0) && (rdW == rs1E)) fwd_a = 2'b01;

    fwd_b = 2'b00;
    if (regwriteM && (rdM != 5'd0) && (rdM == rs2E))      fwd_b = 2'b10;
    else if (regwriteW && (rdW != 5'd0) && (rdW == rs2E)) fwd_b = 2'b01;
  end

  assign lu = (wbselE == LOAD_WBSEL) && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

  // Multi-cycle sequencer: the start cycle counts as the first EX-occupancy cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mc_hold  = 1'b0;
    mc_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (mc_reqE && (!pcselE || (MC_LAT == 1))) begin
          mc_start = 1'b1;
          if (MC_LAT > 1) begin
            mc_hold = 1'b1;
            state_d = BUSY;
            cnt_d   = CNT_START;
          end
        end
      end
      BUSY: begin
        if (pcselE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          mc_hold = 1'b1;
          cnt_d   = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // A redirect wins over every stall; a held EX register is never cleared.
  assign stall_e  = !pcselE && mc_hold;
  assign stall_fd = !pcselE && (mc_hold || lu);
  assign flush_e  = !stall_e && (pcselE || lu);

  assign forwardAE    = rst ? 2'b00 : fwd_a;
  assign forwardBE    = rst ? 2'b00 : fwd_b;
  assign stallF       = !rst && stall_fd;
  assign stallD       = !rst && stall_fd;
  assign stallE       = !rst && stall_e;
  assign flushD       = !rst && pcselE;
  assign flushE       = !rst && flush_e;
  assign mc_go        = !rst && mc_start;
  assign mc_busy      = !rst && (state_q == BUSY);
  assign stall_cycles = stall_cycles_q;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall_fd && (stall_cycles_q != STALL_MAX)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Bench for ex_hazard_ctrl: vector table, directed multi-cycle sequences and
// randomized traffic against an occupancy-count reference model.
module tb_ex_hazard_ctrl;

  localparam int MC_LAT = 4;

  logic       clk, rst;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [1:0] wbselE;
  logic       regwriteM, regwriteW, pcselE, mc_reqE;

  logic [1:0]  fa_m, fb_m, fa_s, fb_s;
  logic        sF_m, sD_m, sE_m, fD_m, fE_m, go_m, busy_m;
  logic        sF_s, sD_s, sE_s, fD_s, fE_s, go_s, busy_s;
  logic [15:0] cnt_m;
  logic [1:0]  cnt_s;
  logic [10:0] ctrl_m, ctrl_s;

  int n_pass, n_total;
  int mc_left;
  int model_cnt16, model_cnt2;

  ex_hazard_ctrl #(.MC_LAT(MC_LAT), .LOAD_WBSEL(2'b00), .CNT_W(16)) u_main (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .wbselE(wbselE), .regwriteM(regwriteM),
    .regwriteW(regwriteW), .pcselE(pcselE), .mc_reqE(mc_reqE),
    .forwardAE(fa_m), .forwardBE(fb_m), .stallF(sF_m), .stallD(sD_m), .stallE(sE_m),
    .flushD(fD_m), .flushE(fE_m), .mc_go(go_m), .mc_busy(busy_m), .stall_cycles(cnt_m)
  );

  ex_hazard_ctrl #(.MC_LAT(MC_LAT), .LOAD_WBSEL(2'b00), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .wbselE(wbselE), .regwriteM(regwriteM),
    .regwriteW(regwriteW), .pcselE(pcselE), .mc_reqE(mc_reqE),
    .forwardAE(fa_s), .forwardBE(fb_s), .stallF(sF_s), .stallD(sD_s), .stallE(sE_s),
    .flushD(fD_s), .flushE(fE_s), .mc_go(go_s), .mc_busy(busy_s), .stall_cycles(cnt_s)
  );

  assign ctrl_m = {fa_m, fb_m, sF_m, sD_m, sE_m, fD_m, fE_m, go_m, busy_m};
  assign ctrl_s = {fa_s, fb_s, sF_s, sD_s, sE_s, fD_s, fE_s, go_s, busy_s};

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- helpers ----------------
  function automatic logic [10:0] pk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic sf, input logic sd, input logic se,
                                     input logic fd, input logic fe, input logic go,
                                     input logic busy);
    return {fa, fb, sf, sd, se, fd, fe, go, busy};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // ---------------- reference model ----------------
  // mc_left = EX-occupancy cycles of the running op still to go, current cycle included.
  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [10:0] model_ctrl();
    logic lu, busy, starts, hold, sf, fe;
    if (rst) return '0;
    lu     = (wbselE == 2'b00) && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    busy   = mc_left > 0;
    starts = !busy && mc_reqE && (!pcselE || MC_LAT == 1);
    hold   = !pcselE && (busy ? (mc_left > 1) : (starts && MC_LAT > 1));
    sf     = !pcselE && (hold || lu);
    fe     = !hold && (pcselE || lu);
    return pk(m_fwd(rs1E), m_fwd(rs2E), sf, sf, hold, pcselE, fe, starts, busy);
  endfunction

  task automatic model_update(input logic [10:0] e);
    if (rst) begin
      mc_left = 0; model_cnt16 = 0; model_cnt2 = 0;
      return;
    end
    if (e[6]) begin
      model_cnt16 = (model_cnt16 + 1 > 65535) ? 65535 : model_cnt16 + 1;
      model_cnt2  = (model_cnt2 + 1 > 3) ? 3 : model_cnt2 + 1;
    end
    if (mc_left == 0) begin
      if (e[1] && MC_LAT > 1) mc_left = MC_LAT - 1;
    end else if (pcselE) mc_left = 0;
    else mc_left = mc_left - 1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    logic [10:0] e;
    e = model_ctrl();
    @(posedge clk);
    model_update(e);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    wbselE = 2'b01; regwriteM = 0; regwriteW = 0; pcselE = 0; mc_reqE = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_update('0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic model_check(input string tag);
    #2;
    chk({tag, " ctrl"}, 32'(ctrl_m), 32'(model_ctrl()));
    chk({tag, " ctrl_sat"}, 32'(ctrl_s), 32'(model_ctrl()));
    chk({tag, " cnt16"}, 32'(cnt_m), 32'(model_cnt16));
    chk({tag, " cnt2"}, 32'(cnt_s), 32'(model_cnt2));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [4:0]  rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [1:0]  wb;
    logic        rwM, rwW, pc;
    logic [10:0] exp;
  } vec_t;

  vec_t tv[11];

  initial begin
    n_pass = 0; n_total = 0;
    mc_left = 0; model_cnt16 = 0; model_cnt2 = 0;
    rst = 1'b1;
    clear_inputs();

    tv[0]  = '{0, 0, 5, 0, 0, 5, 5, 2'b01, 1, 1, 0, pk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0)};
    tv[1]  = '{0, 0, 5, 0, 0, 0, 5, 2'b01, 1, 1, 0, pk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0)};
    tv[2]  = '{0, 0, 5, 0, 0, 0, 5, 2'b01, 1, 0, 0, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)};
    tv[3]  = '{3, 7, 0, 1, 7, 0, 0, 2'b00, 0, 0, 0, pk(2'b00, 2'b00, 1, 1, 0, 0, 1, 0, 0)};
    tv[4]  = '{0, 0, 0, 7, 0, 0, 7, 2'b01, 0, 1, 0, pk(2'b00, 2'b01, 0, 0, 0, 0, 0, 0, 0)};
    tv[5]  = '{7, 0, 0, 0, 7, 0, 0, 2'b00, 0, 0, 1, pk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0, 0)};
    tv[6]  = '{0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)};
    tv[7]  = '{0, 0, 3, 4, 0, 4, 3, 2'b01, 1, 1, 0, pk(2'b01, 2'b10, 0, 0, 0, 0, 0, 0, 0)};
    tv[8]  = '{0, 0, 3, 0, 0, 3, 3, 2'b01, 0, 1, 0, pk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0)};
    tv[9]  = '{7, 0, 0, 0, 7, 0, 0, 2'b10, 0, 0, 0, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)};
    tv[10] = '{0, 0, 0, 0, 0, 0, 0, 2'b01, 1, 1, 0, pk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0)};

    // Reset state, with inputs that would otherwise forward and stall.
    @(negedge clk);
    rs1E = 5; rdM = 5; regwriteM = 1; wbselE = 2'b00; rdE = 7; rs1D = 7; mc_reqE = 1;
    #2;
    chk("reset ctrl", 32'(ctrl_m), 32'(0));
    chk("reset cnt16", 32'(cnt_m), 32'(0));
    tick();
    clear_inputs();
    rst = 1'b0;
    tick();

    // Table-driven vectors, FSM idle throughout.
    for (int i = 0; i < 11; i++) begin
      rs1D = tv[i].rs1D; rs2D = tv[i].rs2D; rs1E = tv[i].rs1E; rs2E = tv[i].rs2E;
      rdE = tv[i].rdE; rdM = tv[i].rdM; rdW = tv[i].rdW; wbselE = tv[i].wb;
      regwriteM = tv[i].rwM; regwriteW = tv[i].rwW; pcselE = tv[i].pc; mc_reqE = 0;
      #2;
      chk($sformatf("vec%0d", i), 32'(ctrl_m), 32'(tv[i].exp));
      tick();
    end
    clear_inputs();

    // Multi-cycle op with mc_reqE held for the whole occupancy.
    do_reset();
    mc_reqE = 1;
    #2; chk("mc c0", 32'(ctrl_m), 32'(pk(0, 0, 1, 1, 1, 0, 0, 1, 0))); tick();
    #2; chk("mc c1", 32'(ctrl_m), 32'(pk(0, 0, 1, 1, 1, 0, 0, 0, 1))); tick();
    #2; chk("mc c2", 32'(ctrl_m), 32'(pk(0, 0, 1, 1, 1, 0, 0, 0, 1))); tick();
    #2; chk("mc c3", 32'(ctrl_m), 32'(pk(0, 0, 0, 0, 0, 0, 0, 0, 1)));
    chk("mc cnt after op", 32'(cnt_m), 32'(3)); tick();
    mc_reqE = 0;
    #2; chk("mc idle", 32'(ctrl_m), 32'(0)); tick();

    // Two load-use cycles: five stall edges total, the narrow counter saturates.
    wbselE = 2'b00; rdE = 9; rs1D = 9;
    #2; chk("lu stall", 32'(ctrl_m), 32'(pk(0, 0, 1, 1, 0, 0, 1, 0, 0))); tick();
    tick();
    clear_inputs();
    #2;
    chk("sat cnt16", 32'(cnt_m), 32'(5));
    chk("sat cnt2", 32'(cnt_s), 32'(3));
    tick();

    // Redirect in the first BUSY cycle aborts the op.
    do_reset();
    mc_reqE = 1;
    #2; chk("abort c0", 32'(ctrl_m), 32'(pk(0, 0, 1, 1, 1, 0, 0, 1, 0))); tick();
    pcselE = 1;
    #2; chk("abort c1", 32'(ctrl_m), 32'(pk(0, 0, 0, 0, 0, 1, 1, 0, 1))); tick();
    pcselE = 0; mc_reqE = 0;
    #2; chk("abort c2", 32'(ctrl_m), 32'(0)); tick();

    // Async reset in the middle of BUSY.
    mc_reqE = 1;
    tick();
    #2; chk("rst pre busy", 32'(busy_m), 32'(1));
    #1; rst = 1'b1; model_update('0);
    #1;
    chk("rst mid ctrl", 32'(ctrl_m), 32'(0));
    chk("rst mid cnt", 32'(cnt_m), 32'(0));
    mc_reqE = 0;
    tick();
    rst = 1'b0;
    #2; chk("rst release", 32'(ctrl_m), 32'(0)); tick();

    // Randomized traffic against the model.
    for (int c = 0; c < 400; c++) begin
      rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
      rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
      rdE = 5'($urandom_range(0, 3)); rdM = 5'($urandom_range(0, 3));
      rdW = 5'($urandom_range(0, 3)); wbselE = 2'($urandom_range(0, 3));
      regwriteM = 1'($urandom_range(0, 1)); regwriteW = 1'($urandom_range(0, 1));
      mc_reqE = ($urandom_range(0, 2) == 0);
      pcselE = ($urandom_range(0, 7) == 0);
      model_check($sformatf("rand%0d", c));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
